// File: rtl/memtest_ctrl.sv
// memtest_ctrl: control FSM for the memory built-in self-test.
// For each pass it runs a write sweep over every address, then a
// read/compare sweep. It strobes the address/data datapath and the SRAM
// enables, and reacts to the datapath done (last address) and error flags.
//
// Parameters:
//   NUM_PASSES : number of test passes (1..8, pass index 0..NUM_PASSES-1)
//   READ_LAT   : SRAM read latency, cycles spent in RD before CHECK (1..15)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   start    in   begin test, sampled only in IDLE
//   done     in   datapath address register is at the last address
//   error    in   sticky compare-error flag from the datapath
//   pass     out  current pass index (datapath pattern mux)
//   state    out  current state encoding (datapath compare qualifier)
//   loadA    out  increment datapath address register
//   loadD    out  load datapath write/expect data register
//   we       out  SRAM write enable
//   re       out  SRAM read enable
//   busy     out  high in every state except IDLE and DONE
//   complete out  high in DONE
//   fail     out  high in DONE when the error flag was set
//
// Build option: define STOP_ON_ERROR_EN to end the test at the first error
// seen during a read sweep (pass index freezes at the failing pass).
module memtest_ctrl #(
  parameter int NUM_PASSES = 4,
  parameter int READ_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  input  logic       error,
  output logic [2:0] pass,
  output logic [2:0] state,
  output logic       loadA,
  output logic       loadD,
  output logic       we,
  output logic       re,
  output logic       busy,
  output logic       complete,
  output logic       fail
);

  // The encoding is visible to the datapath; CHECK must stay 3'b100.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_INCA  = 3'b001;
  localparam logic [2:0] S_LDD   = 3'b010;
  localparam logic [2:0] S_WR    = 3'b011;
  localparam logic [2:0] S_CHECK = 3'b100;
  localparam logic [2:0] S_RD    = 3'b101;
  localparam logic [2:0] S_DONE  = 3'b110;

  localparam logic PH_WRITE = 1'b0;
  localparam logic PH_READ  = 1'b1;

  localparam logic [2:0] LAST_PASS = 3'(NUM_PASSES - 1);
  localparam logic [3:0] LAT_INIT  = 4'(READ_LAT - 1);

  logic       phase;
  logic [3:0] lat_cnt;
  logic       err_seen;

  logic [2:0] next_state;
  logic [2:0] next_pass;
  logic       next_phase;
  logic [3:0] next_cnt;

  always_comb begin
    next_state = state;
    next_pass  = pass;
    next_phase = phase;
    next_cnt   = lat_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_INCA;
          next_phase = PH_WRITE;
        end
      end
      // Address steps before the data load so the pattern mux sees the new address.
      S_INCA: next_state = S_LDD;
      S_LDD: begin
        if (phase == PH_READ) begin
          next_state = S_RD;
          next_cnt   = LAT_INIT;
        end else begin
          next_state = S_WR;
        end
      end
      S_WR: begin
        next_state = S_INCA;
        if (done) next_phase = PH_READ;
      end
      S_RD: begin
        if (lat_cnt == 4'd0) next_state = S_CHECK;
        else                 next_cnt   = lat_cnt - 4'd1;
      end
      S_CHECK: begin
        if (!done) begin
          next_state = S_INCA;
        end else if (pass == LAST_PASS) begin
          next_state = S_DONE;
        end else begin
          next_state = S_INCA;
          next_pass  = pass + 3'd1;
          next_phase = PH_WRITE;
        end
      end
      S_DONE: next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
`ifdef STOP_ON_ERROR_EN
    // Abort only from active states; the failing pass index is kept.
    if (error && (state != S_IDLE) && (state != S_DONE) && (state != 3'b111) &&
        ((state == S_CHECK) || (phase == PH_READ))) begin
      next_state = S_DONE;
      next_pass  = pass;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pass     <= 3'd0;
      phase    <= PH_WRITE;
      lat_cnt  <= 4'd0;
      err_seen <= 1'b0;
    end else begin
      state    <= next_state;
      pass     <= next_pass;
      phase    <= next_phase;
      lat_cnt  <= next_cnt;
      // Registered copy keeps fail free of any input-to-output path.
      err_seen <= error;
    end
  end

  assign loadA    = (state == S_INCA);
  assign loadD    = (state == S_LDD);
  assign we       = (state == S_WR);
  assign re       = (state == S_RD);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign complete = (state == S_DONE);
  assign fail     = (state == S_DONE) && err_seen;

endmodule

// File: tb/tb_memtest_ctrl.sv
module tb_memtest_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: one pass, read latency 1. Instance 4: four passes, latency 2.
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       done1, done4, error1, error4;
  logic [2:0] pass1, pass4, state1, state4;
  logic       la1, ld1, we1, re1, busy1, comp1, fail1;
  logic       la4, ld4, we4, re4, busy4, comp4, fail4;

  memtest_ctrl #(.NUM_PASSES(1), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .done(done1), .error(error1),
    .pass(pass1), .state(state1), .loadA(la1), .loadD(ld1), .we(we1), .re(re1),
    .busy(busy1), .complete(comp1), .fail(fail1));

  memtest_ctrl #(.NUM_PASSES(4), .READ_LAT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .done(done4), .error(error4),
    .pass(pass4), .state(state4), .loadA(la4), .loadD(ld4), .we(we4), .re(re4),
    .busy(busy4), .complete(comp4), .fail(fail4));

  // 4-address datapath models: address resets to all ones, done at address 3,
  // sticky error set by the compare at an injected (pass, address).
  logic [1:0] addr1, addr4;
  logic       err4;
  logic       err_en_v = 1'b0;
  logic [2:0] ep_v = 3'd0;
  logic [1:0] ea_v = 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr1 <= 2'd3;
      addr4 <= 2'd3;
      err4  <= 1'b0;
    end else begin
      if (la1) addr1 <= addr1 + 2'd1;
      if (la4) addr4 <= addr4 + 2'd1;
      if (err_en_v && state4 == 3'b100 && pass4 == ep_v && addr4 == ea_v) err4 <= 1'b1;
    end
  end
  assign done1  = (addr1 == 2'd3);
  assign done4  = (addr4 == 2'd3);
  assign error1 = 1'b0;
  assign error4 = err4;

  // Observation mux onto the instance under test.
  int sel_v = 4;
  logic [2:0] o_state, o_pass;
  logic o_la, o_ld, o_we, o_re, o_busy, o_comp, o_fail;
  always_comb begin
    if (sel_v == 1) begin
      o_state = state1; o_pass = pass1; o_la = la1; o_ld = ld1; o_we = we1;
      o_re = re1; o_busy = busy1; o_comp = comp1; o_fail = fail1;
    end else begin
      o_state = state4; o_pass = pass4; o_la = la4; o_ld = ld4; o_we = we4;
      o_re = re4; o_busy = busy4; o_comp = comp4; o_fail = fail4;
    end
  end

  int nchecks = 0;
  int nerr = 0;
  bit last_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    last_bad = 1'b0;
    if (act !== exp) begin
      nerr++;
      last_bad = 1'b1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: ordered list of (state, pass) the controller must visit.
  typedef struct {
    logic [2:0] st;
    logic [2:0] ps;
  } tr_t;
  tr_t exp_q[$];

  function automatic void push(input logic [2:0] s, input int p);
    tr_t t;
    t.st = s;
    t.ps = 3'(p);
    exp_q.push_back(t);
  endfunction

  function automatic void gen_trace(input int np, input int rl, input bit err_en,
                                    input int ep, input int ea);
    bit abort = 1'b0;
`ifdef STOP_ON_ERROR_EN
    abort = err_en;
`endif
    exp_q.delete();
    for (int p = 0; p < np; p++) begin
      for (int a = 0; a < 4; a++) begin
        push(3'b001, p); push(3'b010, p); push(3'b011, p);
      end
      for (int a = 0; a < 4; a++) begin
        push(3'b001, p); push(3'b010, p);
        for (int k = 0; k < rl; k++) push(3'b101, p);
        push(3'b100, p);
        if (abort && p == ep && a == ea) begin
          // Error is visible one cycle after the compare; that cycle is spent
          // in INCA, then DONE, unless this compare was already the last one.
          if (!(p == np - 1 && a == 3)) push(3'b001, p);
          return;
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    #1;
    chk("reset_dut1", {state1, pass1, la1, ld1, we1, re1, busy1, comp1, fail1}, 32'd0);
    chk("reset_dut4", {state4, pass4, la4, ld4, we4, re4, busy4, comp4, fail4}, 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_start(input logic v);
    if (sel_v == 1) start1 = v;
    else            start4 = v;
  endtask

  task automatic run_trace(input int sel, input int np, input int rl, input bit err_en,
                           input int ep, input int ea, output int busy_cnt);
    bit abort = 1'b0;
    int exp_pass;
    logic [31:0] expv;
`ifdef STOP_ON_ERROR_EN
    abort = err_en;
`endif
    busy_cnt = 0;
    sel_v    = sel;
    err_en_v = err_en;
    ep_v     = 3'(ep);
    ea_v     = 2'(ea);
    gen_trace(np, rl, err_en, ep, ea);
    exp_pass = abort ? ep : np - 1;
    do_reset();
    set_start(1'b1);
    step();
    foreach (exp_q[i]) begin
      expv = {exp_q[i].st, exp_q[i].ps,
              exp_q[i].st == 3'b001, exp_q[i].st == 3'b010,
              exp_q[i].st == 3'b011, exp_q[i].st == 3'b101, 1'b1, 1'b0};
      chk($sformatf("trace[%0d]", i),
          {o_state, o_pass, o_la, o_ld, o_we, o_re, o_busy, o_comp}, expv);
      if (last_bad) return;
      if (o_busy) busy_cnt++;
      step();
      set_start(1'($urandom_range(0, 1)));
    end
    chk("done_state", {o_state, o_pass, o_comp, o_busy, o_la, o_ld, o_we, o_re},
        {3'b110, 3'(exp_pass), 1'b1, 1'b0, 4'b0000});
    set_start(1'b1);
    step();
    step();
    set_start(1'b0);
    chk("done_hold_fail", {o_state, o_pass, o_fail}, {3'b110, 3'(exp_pass), err_en});
  endtask

  typedef struct {
    bit err_en;
    int ep;
    int ea;
    int exp_busy;
    bit exp_fail;
    int exp_pass;
  } vec_t;
  vec_t vt[5];

  initial begin
    int bc;
    bit    e;
    int    p, a;

`ifdef STOP_ON_ERROR_EN
    vt[0] = '{1'b0, 0, 0, 128, 1'b0, 3};
    vt[1] = '{1'b1, 1, 2, 60,  1'b1, 1};
    vt[2] = '{1'b1, 0, 0, 18,  1'b1, 0};
    vt[3] = '{1'b1, 3, 3, 128, 1'b1, 3};
    vt[4] = '{1'b1, 2, 1, 87,  1'b1, 2};
`else
    vt[0] = '{1'b0, 0, 0, 128, 1'b0, 3};
    vt[1] = '{1'b1, 1, 2, 128, 1'b1, 3};
    vt[2] = '{1'b1, 0, 0, 128, 1'b1, 3};
    vt[3] = '{1'b1, 3, 3, 128, 1'b1, 3};
    vt[4] = '{1'b1, 2, 1, 128, 1'b1, 3};
`endif

    // Reset then idle with start low.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {state4, pass4, la4, ld4, we4, re4, busy4, comp4}, 32'd0);
    end

    // Single pass, latency 1: 28 busy cycles.
    run_trace(1, 1, 1, 1'b0, 0, 0, bc);
    chk("single_pass_cycles", bc, 32'd28);

    // Table of four-pass runs, latency 2.
    for (int i = 0; i < 5; i++) begin
      run_trace(4, 4, 2, vt[i].err_en, vt[i].ep, vt[i].ea, bc);
      chk($sformatf("vec%0d_cycles", i), bc, 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_end", i), {o_pass, o_fail}, {3'(vt[i].exp_pass), vt[i].exp_fail});
    end

    // Randomized error injection on read sweeps.
    for (int i = 0; i < 6; i++) begin
      e = 1'($urandom_range(0, 1));
      p = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 2));
      run_trace(4, 4, 2, e, p, a, bc);
      chk($sformatf("rand%0d_cycles", i), bc, 32'(exp_q.size()));
    end

    // Reset in the middle of a write in pass 2.
    sel_v = 4;
    err_en_v = 1'b0;
    do_reset();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (66) step();
    chk("mid_in_wr", {o_state, o_pass, o_we}, {3'b011, 3'd2, 1'b1});
    rst = 1'b1;
    #1;
    chk("mid_reset", {o_state, o_pass, o_we, o_la, o_ld, o_re, o_busy}, 32'd0);
    step();
    rst = 1'b0;
    run_trace(4, 4, 2, 1'b0, 0, 0, bc);
    chk("restart_cycles", bc, 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
